// File: rtl/rs_encode_line_in_ctrl.sv
// Line-input sequencing FSM for the Reed-Solomon encoder: line handshake, byte stepping, message end.
// Optional RS_ENCODE_IN_CTRL_BUBBLE_FREE_EN lets the next line load on the current line's last byte.
module rs_encode_line_in_ctrl #(
  parameter int NUM_LINES  = -1,
  parameter int DATA_BYTES = -1
) (
  input  logic clk,
  input  logic rst,
  input  logic src_encoder_line_val,
  output logic encoder_src_line_rdy,
  output logic in_ctrl_encoder_data_val,
  input  logic encoder_in_ctrl_data_rdy,
  output logic in_ctrl_encoder_data_last,
  output logic in_ctrl_src_msg_done,
  output logic in_ctrl_in_datap_init_state,
  output logic in_ctrl_in_datap_store_in_line,
  output logic in_ctrl_in_datap_incr_byte_offset,
  input  logic in_datap_in_ctrl_last_line_byte,
  input  logic in_datap_in_ctrl_last_line
);

  // The datapath relies on a power-of-two line width for its byte offset to wrap cleanly.
  if (NUM_LINES < 1 || DATA_BYTES < 1 || (DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_param_check
    $error("rs_encode_line_in_ctrl: NUM_LINES must be >= 1 and DATA_BYTES a power of two");
  end

  localparam logic [1:0] ST_READY    = 2'd0;
  localparam logic [1:0] ST_OUTPUT   = 2'd1;
  localparam logic [1:0] ST_MSG_DONE = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d                           = state_q;
    encoder_src_line_rdy              = 1'b0;
    in_ctrl_encoder_data_val          = 1'b0;
    in_ctrl_encoder_data_last         = 1'b0;
    in_ctrl_src_msg_done              = 1'b0;
    in_ctrl_in_datap_init_state       = 1'b0;
    in_ctrl_in_datap_store_in_line    = 1'b0;
    in_ctrl_in_datap_incr_byte_offset = 1'b0;

    case (state_q)
      ST_READY: begin
        encoder_src_line_rdy = 1'b1;
        if (src_encoder_line_val) begin
          in_ctrl_in_datap_store_in_line = 1'b1;
          state_d                        = ST_OUTPUT;
        end
      end

      ST_OUTPUT: begin
        in_ctrl_encoder_data_val  = 1'b1;
        in_ctrl_encoder_data_last = in_datap_in_ctrl_last_line & in_datap_in_ctrl_last_line_byte;
        if (encoder_in_ctrl_data_rdy) begin
          in_ctrl_in_datap_incr_byte_offset = 1'b1;
          if (in_datap_in_ctrl_last_line_byte) begin
            if (in_datap_in_ctrl_last_line) begin
              state_d = ST_MSG_DONE;
            end else begin
`ifdef RS_ENCODE_IN_CTRL_BUBBLE_FREE_EN
              // Prefetch the next line in the same cycle its predecessor's last byte leaves.
              encoder_src_line_rdy = 1'b1;
              if (src_encoder_line_val) begin
                in_ctrl_in_datap_store_in_line = 1'b1;
              end else begin
                state_d = ST_READY;
              end
`else
              state_d = ST_READY;
`endif
            end
          end
        end
      end

      ST_MSG_DONE: begin
        in_ctrl_in_datap_init_state = 1'b1;
        in_ctrl_src_msg_done        = 1'b1;
        state_d                     = ST_READY;
      end

      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_READY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_rs_encode_line_in_ctrl.sv
// Scoreboard bench for rs_encode_line_in_ctrl with a behavioural line-input datapath around it.
// Honours RS_ENCODE_IN_CTRL_BUBBLE_FREE_EN for the expected message length.
module tb_rs_encode_line_in_ctrl;

  localparam int NUM_LINES  = 3;
  localparam int DATA_BYTES = 4;
  localparam int LAST_BYTES = 2;
`ifdef RS_ENCODE_IN_CTRL_BUBBLE_FREE_EN
  localparam int MSG_CYCLES = 11;
`else
  localparam int MSG_CYCLES = 13;
`endif

  logic clk;
  logic rst;
  logic src_val;
  logic src_rdy;
  logic data_val;
  logic enc_rdy;
  logic data_last;
  logic msg_done;
  logic init_state;
  logic store_line;
  logic incr_off;
  logic last_line_byte;
  logic last_line;
  logic [31:0] src_line;

  logic [31:0] dp_line_q;
  logic [1:0]  dp_off_q;
  logic [1:0]  dp_lcnt_q;
  logic [7:0]  dp_byte;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int enc_mode = 3;
  int mli = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int done_cycle = 0;
  int first_hs_cycle = 0;
  bit src_busy = 0;

  logic [31:0] src_q[$];
  int          gap_q[$];
  logic [7:0]  exp_byte_q[$];
  bit          exp_last_q[$];

  rs_encode_line_in_ctrl #(
    .NUM_LINES (NUM_LINES),
    .DATA_BYTES(DATA_BYTES)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .src_encoder_line_val             (src_val),
    .encoder_src_line_rdy             (src_rdy),
    .in_ctrl_encoder_data_val         (data_val),
    .encoder_in_ctrl_data_rdy         (enc_rdy),
    .in_ctrl_encoder_data_last        (data_last),
    .in_ctrl_src_msg_done             (msg_done),
    .in_ctrl_in_datap_init_state      (init_state),
    .in_ctrl_in_datap_store_in_line   (store_line),
    .in_ctrl_in_datap_incr_byte_offset(incr_off),
    .in_datap_in_ctrl_last_line_byte  (last_line_byte),
    .in_datap_in_ctrl_last_line       (last_line)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Datapath stand-in: line register, byte offset, line count; last line carries LAST_BYTES bytes.
  assign last_line      = (dp_lcnt_q == 2'(NUM_LINES - 1));
  assign last_line_byte = last_line ? (dp_off_q == 2'(LAST_BYTES - 1)) : (dp_off_q == 2'(DATA_BYTES - 1));
  assign dp_byte        = 8'(dp_line_q >> (8 * (3 - int'(dp_off_q))));

  always @(posedge clk) begin
    if (rst || init_state) begin
      dp_off_q  <= 2'd0;
      dp_lcnt_q <= 2'd0;
    end else begin
      if (store_line) dp_line_q <= src_line;
      if (incr_off) begin
        if (last_line_byte) begin
          dp_off_q  <= 2'd0;
          dp_lcnt_q <= dp_lcnt_q + 2'd1;
        end else begin
          dp_off_q <= dp_off_q + 2'd1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] line, input int gap);
    src_q.push_back(line);
    gap_q.push_back(gap);
  endtask

  // Reference model: a message is NUM_LINES lines sent MSB first, the last line truncated.
  task automatic model_line(input logic [31:0] line);
    int nb;
    nb = (mli == NUM_LINES - 1) ? LAST_BYTES : DATA_BYTES;
    for (int i = 0; i < nb; i++) begin
      exp_byte_q.push_back(line[31 - 8 * i -: 8]);
      exp_last_q.push_back(mli == NUM_LINES - 1 && i == nb - 1);
    end
    mli = (mli + 1) % NUM_LINES;
  endtask

  initial begin
    enc_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (enc_mode)
        0:       enc_rdy = 1'b1;
        1:       enc_rdy = ~enc_rdy;
        2:       enc_rdy = 1'($urandom_range(0, 1));
        default: enc_rdy = 1'b0;
      endcase
    end
  end

  // Source: presents queued lines after their gap and holds each until the handshake.
  initial begin
    logic [31:0] line;
    int g;
    int waited;
    bit hs;
    src_val  = 1'b0;
    src_line = 32'd0;
    forever begin
      if (src_q.size() == 0) begin
        src_val  = 1'b0;
        src_busy = 0;
        @(posedge clk);
        #1;
      end else begin
        src_busy = 1;
        g    = gap_q.pop_front();
        line = src_q.pop_front();
        if (g > 0) begin
          src_val = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
        src_val  = 1'b1;
        src_line = line;
        waited   = 0;
        hs       = 0;
        while (!hs && waited < 200) begin
          @(negedge clk);
          hs = src_val && src_rdy && !rst;
          waited++;
        end
        if (hs) begin
          if (mli == 0) first_hs_cycle = cycle;
          model_line(line);
        end else begin
          checkOutput("line_handshake", 32'(hs), 32'd1);
        end
        @(posedge clk);
        #1;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and checks handshake rules each cycle.
  initial begin
    bit prev_hs = 0;
    bit prev_stall = 0;
    bit done_exp = 0;
    bit done_next;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_byte_q.delete();
        exp_last_q.delete();
        mli = 0;
        prev_hs = 0;
        prev_stall = 0;
        done_exp = 0;
        continue;
      end
      if (prev_hs)    checkOutput("val_after_line", 32'(data_val), 32'd1);
      if (prev_stall) checkOutput("val_held_stall", 32'(data_val), 32'd1);
      checkOutput("incr_rule", 32'(incr_off), 32'(data_val && enc_rdy));
      checkOutput("msg_done", 32'(msg_done), 32'(done_exp));
      checkOutput("init_state", 32'(init_state), 32'(done_exp));
      if (data_val && store_line)
        checkOutput("store_overwrite", 32'(enc_rdy && last_line_byte && !last_line), 32'd1);
      done_next = 0;
      if (data_val && enc_rdy) begin
        acc_cnt++;
        if (exp_byte_q.size() == 0) begin
          checkOutput("unexpected_byte", 32'(dp_byte), 32'hFFFF_FFFF);
        end else begin
          checkOutput("byte", 32'(dp_byte), 32'(exp_byte_q[0]));
          checkOutput("data_last", 32'(data_last), 32'(exp_last_q[0]));
          done_next = exp_last_q[0];
          void'(exp_byte_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      if (msg_done) begin
        done_cnt++;
        done_cycle = cycle;
      end
      prev_hs    = src_val && src_rdy;
      prev_stall = data_val && !enc_rdy;
      done_exp   = done_next;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((src_q.size() != 0 || src_busy || exp_byte_q.size() != 0) && n < 2000);
    checkOutput("idle_reached", 32'(n < 2000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_msg(input logic [31:0] base, input int gap1);
    applyStimulus(base, 0);
    applyStimulus(base + 32'h0404_0404, gap1);
    applyStimulus(base + 32'h0808_0808, 0);
  endtask

  initial begin
    int d0;
    int a0;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_src_rdy", 32'(src_rdy), 32'd1);
    checkOutput("rst_data_val", 32'(data_val), 32'd0);
    checkOutput("rst_data_last", 32'(data_last), 32'd0);
    checkOutput("rst_msg_done", 32'(msg_done), 32'd0);
    checkOutput("rst_init", 32'(init_state), 32'd0);
    checkOutput("rst_store", 32'(store_line), 32'd0);
    checkOutput("rst_incr", 32'(incr_off), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    enc_mode = 0;

    d0 = done_cnt;
    send_msg(32'h0001_0203, 0);
    wait_idle();
    checkOutput("msg_cycles", 32'(done_cycle - first_hs_cycle), 32'(MSG_CYCLES));
    checkOutput("done_count_a", 32'(done_cnt - d0), 32'd1);

    enc_mode = 1;
    d0 = done_cnt;
    send_msg(32'h0001_0203, 0);
    wait_idle();
    checkOutput("done_count_toggle", 32'(done_cnt - d0), 32'd1);

    enc_mode = 0;
    d0 = done_cnt;
    send_msg(32'h0001_0203, 5);
    wait_idle();
    checkOutput("done_count_delay", 32'(done_cnt - d0), 32'd1);

    // Abort mid-message right after the sixth byte (0x05) is consumed.
    d0 = done_cnt;
    a0 = acc_cnt;
    applyStimulus(32'h0001_0203, 0);
    applyStimulus(32'h0405_0607, 0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (acc_cnt < a0 + 6 && n < 200);
    checkOutput("reach_byte05", 32'(acc_cnt - a0), 32'd6);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_data_val", 32'(data_val), 32'd0);
    checkOutput("abort_src_rdy", 32'(src_rdy), 32'd1);
    checkOutput("abort_msg_done", 32'(msg_done), 32'd0);
    @(posedge clk);
    #1;
    send_msg(32'h1112_1314, 0);
    wait_idle();
    checkOutput("done_count_abort", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    send_msg(32'h2021_2223, 0);
    send_msg(32'h3031_3233, 0);
    wait_idle();
    checkOutput("done_count_b2b", 32'(done_cnt - d0), 32'd2);

    enc_mode = 2;
    d0 = done_cnt;
    for (int m = 0; m < 6; m++) begin
      for (int l = 0; l < NUM_LINES; l++) applyStimulus($urandom, int'($urandom_range(0, 3)));
    end
    wait_idle();
    checkOutput("done_count_rand", 32'(done_cnt - d0), 32'd6);
    checkOutput("queue_empty", 32'(exp_byte_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    total++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
